// File: rtl/rate_select_controller.sv
// Button-driven rate selector: synchronises and debounces two push-buttons, then
// steps through a fixed divider table with hold-to-repeat and both-button recall.
module rate_select_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 50000000,
  parameter int DEFAULT_INDEX   = 3
) (
  input  logic        basys_clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [31:0] m_value,
  output logic [2:0]  rate_index,
  output logic        rate_changed,
  output logic        at_limit
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
  localparam logic [2:0]      DEF_IDX = 3'(DEFAULT_INDEX);

  typedef enum logic [1:0] {IDLE, UP_HELD, DOWN_HELD, BOTH_HELD} state_t;

  function automatic logic [31:0] rate_table(input logic [2:0] idx);
    case (idx)
      3'd0:    rate_table = 32'd49999999;
      3'd1:    rate_table = 32'd24999999;
      3'd2:    rate_table = 32'd9999999;
      3'd3:    rate_table = 32'd4999999;
      3'd4:    rate_table = 32'd2499999;
      3'd5:    rate_table = 32'd999999;
      3'd6:    rate_table = 32'd499999;
      default: rate_table = 32'd49999;
    endcase
  endfunction

  // Bit 0 carries the up button, bit 1 the down button.
  logic [1:0]      raw;
  logic [1:0]      sync1, sync2, deb;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {btn_down, btn_up};

  for (genvar g = 0; g < 2; g++) begin : g_deb
    always_ff @(posedge basys_clock or posedge reset) begin
      if (reset) begin
        sync1[g]  <= 1'b0;
        sync2[g]  <= 1'b0;
        deb[g]    <= 1'b0;
        db_cnt[g] <= '0;
      end else begin
        sync1[g] <= raw[g];
        sync2[g] <= sync1[g];
        if (sync2[g] == deb[g]) begin
          db_cnt[g] <= '0;
        end else if (db_cnt[g] == DB_LAST) begin
          deb[g]    <= sync2[g];
          db_cnt[g] <= '0;
        end else begin
          db_cnt[g] <= db_cnt[g] + 1'b1;
        end
      end
    end
  end

  logic up_d, down_d;
  assign up_d   = deb[0];
  assign down_d = deb[1];

  state_t          state, state_next;
  logic [RP_W-1:0] rep_cnt, rep_next;
  logic            step_up, step_dn, recall;
  logic [2:0]      idx_next;

  // IDLE is only entered with both relevant levels low, so a high level there is a fresh edge.
  always_comb begin
    state_next = state;
    rep_next   = '0;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    recall     = 1'b0;
    case (state)
      IDLE: begin
        if (up_d && down_d) begin
          recall     = 1'b1;
          state_next = BOTH_HELD;
        end else if (up_d) begin
          step_up    = 1'b1;
          state_next = UP_HELD;
        end else if (down_d) begin
          step_dn    = 1'b1;
          state_next = DOWN_HELD;
        end
      end
      UP_HELD: begin
        if (down_d) begin
          recall     = 1'b1;
          state_next = BOTH_HELD;
        end else if (!up_d) begin
          state_next = IDLE;
        end else if (rep_cnt == RP_LAST) begin
          step_up = 1'b1;
        end else begin
          rep_next = rep_cnt + 1'b1;
        end
      end
      DOWN_HELD: begin
        if (up_d) begin
          recall     = 1'b1;
          state_next = BOTH_HELD;
        end else if (!down_d) begin
          state_next = IDLE;
        end else if (rep_cnt == RP_LAST) begin
          step_dn = 1'b1;
        end else begin
          rep_next = rep_cnt + 1'b1;
        end
      end
      default: begin
        if (!up_d && !down_d) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    idx_next = rate_index;
    if (recall)                                idx_next = DEF_IDX;
    else if (step_up && rate_index != 3'd7)    idx_next = rate_index + 3'd1;
    else if (step_dn && rate_index != 3'd0)    idx_next = rate_index - 3'd1;
  end

  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rep_cnt      <= '0;
      rate_index   <= DEF_IDX;
      m_value      <= rate_table(DEF_IDX);
      rate_changed <= 1'b0;
      at_limit     <= (DEF_IDX == 3'd0) || (DEF_IDX == 3'd7);
    end else begin
      state        <= state_next;
      rep_cnt      <= rep_next;
      rate_index   <= idx_next;
      m_value      <= rate_table(idx_next);
      rate_changed <= (idx_next != rate_index);
      at_limit     <= (idx_next == 3'd0) || (idx_next == 3'd7);
    end
  end

endmodule

// File: tb/tb_rate_select_controller.sv
// Directed bench for rate_select_controller with short debounce/repeat timing.
module tb_rate_select_controller;

  logic        basys_clock;
  logic        reset;
  logic        btn_up;
  logic        btn_down;
  logic [31:0] m_value;
  logic [2:0]  rate_index;
  logic        rate_changed;
  logic        at_limit;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int base;

  rate_select_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(20),
    .DEFAULT_INDEX(3)
  ) dut (
    .basys_clock (basys_clock),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .m_value     (m_value),
    .rate_index  (rate_index),
    .rate_changed(rate_changed),
    .at_limit    (at_limit)
  );

  initial begin
    basys_clock = 1'b0;
    forever #5 basys_clock = ~basys_clock;
  end

  // Counts pulses from the value held during the preceding cycle.
  always @(posedge basys_clock) if (rate_changed === 1'b1) pulses++;

  task automatic tick(input int n);
    repeat (n) @(negedge basys_clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;

    // 1. asynchronous reset between edges
    #3 reset = 1'b1;
    #1;
    chk("rst_idx", 32'(rate_index), 32'd3);
    chk("rst_m", m_value, 32'd4999999);
    chk("rst_chg", 32'(rate_changed), 32'd0);
    chk("rst_lim", 32'(at_limit), 32'd0);
    tick(2);
    reset = 1'b0;

    // 2. clean press, update 7 cycles after press
    base = pulses;
    btn_up = 1'b1;
    tick(6);
    chk("press_early_chg", 32'(rate_changed), 32'd0);
    chk("press_early_idx", 32'(rate_index), 32'd3);
    tick(1);
    chk("press_chg", 32'(rate_changed), 32'd1);
    chk("press_idx", 32'(rate_index), 32'd4);
    chk("press_m", m_value, 32'd2499999);
    tick(1);
    chk("press_chg_end", 32'(rate_changed), 32'd0);
    tick(2);
    btn_up = 1'b0;
    tick(12);
    chk("press_pulses", 32'(pulses - base), 32'd1);
    chk("press_hold_idx", 32'(rate_index), 32'd4);

    // 3. bounce shorter than debounce window
    base = pulses;
    for (int i = 0; i < 6; i++) begin
      btn_down = ~btn_down;
      tick(2);
    end
    btn_down = 1'b0;
    tick(15);
    chk("bounce_pulses", 32'(pulses - base), 32'd0);
    chk("bounce_idx", 32'(rate_index), 32'd4);

    // single down step back to 3
    btn_down = 1'b1;
    tick(7);
    chk("down_idx", 32'(rate_index), 32'd3);
    chk("down_chg", 32'(rate_changed), 32'd1);
    tick(3);
    btn_down = 1'b0;
    tick(12);

    // 4. hold-repeat upward with saturation
    base = pulses;
    btn_up = 1'b1;
    tick(7);
    chk("rep_up_first", 32'(rate_index), 32'd4);
    tick(19);
    chk("rep_up_wait", 32'(rate_index), 32'd4);
    tick(1);
    chk("rep_up_5", 32'(rate_index), 32'd5);
    chk("rep_up_5_chg", 32'(rate_changed), 32'd1);
    tick(20);
    chk("rep_up_6", 32'(rate_index), 32'd6);
    tick(20);
    chk("rep_up_7", 32'(rate_index), 32'd7);
    chk("rep_up_lim", 32'(at_limit), 32'd1);
    chk("rep_up_m", m_value, 32'd49999);
    tick(133);
    btn_up = 1'b0;
    tick(12);
    chk("rep_up_pulses", 32'(pulses - base), 32'd4);
    chk("rep_up_sat_idx", 32'(rate_index), 32'd7);

    // hold-repeat downward to 0
    base = pulses;
    btn_down = 1'b1;
    tick(7);
    chk("rep_dn_first", 32'(rate_index), 32'd6);
    chk("rep_dn_lim0", 32'(at_limit), 32'd0);
    tick(120);
    chk("rep_dn_0", 32'(rate_index), 32'd0);
    chk("rep_dn_m", m_value, 32'd49999999);
    chk("rep_dn_lim", 32'(at_limit), 32'd1);
    tick(73);
    btn_down = 1'b0;
    tick(12);
    chk("rep_dn_pulses", 32'(pulses - base), 32'd7);
    chk("rep_dn_sat_idx", 32'(rate_index), 32'd0);

    // climb to index 6
    btn_up = 1'b1;
    tick(107);
    btn_up = 1'b0;
    tick(12);
    chk("climb_idx", 32'(rate_index), 32'd6);

    // 5. both buttons recall
    base = pulses;
    btn_up = 1'b1;
    tick(7);
    chk("both_up_step", 32'(rate_index), 32'd7);
    tick(10);
    btn_down = 1'b1;
    tick(7);
    chk("both_recall_idx", 32'(rate_index), 32'd3);
    chk("both_recall_chg", 32'(rate_changed), 32'd1);
    chk("both_recall_m", m_value, 32'd4999999);
    tick(10);
    btn_up = 1'b0;
    tick(15);
    chk("both_rel_up_idx", 32'(rate_index), 32'd3);
    chk("both_pulses", 32'(pulses - base), 32'd2);
    btn_down = 1'b0;
    tick(12);
    chk("both_rel_dn_idx", 32'(rate_index), 32'd3);
    btn_up = 1'b1;
    tick(7);
    chk("both_after_idx", 32'(rate_index), 32'd4);
    tick(3);
    btn_up = 1'b0;
    tick(12);

    // 6. reset while button held
    btn_up = 1'b1;
    tick(10);
    reset = 1'b1;
    #1;
    chk("held_rst_idx", 32'(rate_index), 32'd3);
    chk("held_rst_chg", 32'(rate_changed), 32'd0);
    tick(2);
    reset = 1'b0;
    base = pulses;
    tick(6);
    chk("held_early_idx", 32'(rate_index), 32'd3);
    tick(1);
    chk("held_step_idx", 32'(rate_index), 32'd4);
    chk("held_step_chg", 32'(rate_changed), 32'd1);
    tick(20);
    chk("held_rep_idx", 32'(rate_index), 32'd5);
    btn_up = 1'b0;
    tick(12);
    chk("held_pulses", 32'(pulses - base), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
